// File: rtl/uart_rx_param_ctl_if.sv
// Receive-side signal bundle for uart_rx_param_ctl: line/enable in, word/status out.
// The slave modport is the receiver; the master modport is whoever drives the line.
interface uart_rx_param_ctl_if #(
  parameter int DATA_BITS = 8
);
  logic                 RX_En_Sig;
  logic                 RX_Pin_In;
  logic [DATA_BITS-1:0] RX_Data;
  logic                 RX_Done_Sig;
  logic                 Parity_Err;
  logic                 Frame_Err;
  logic                 Busy_Sig;

  modport master (
    output RX_En_Sig,
    output RX_Pin_In,
    input  RX_Data,
    input  RX_Done_Sig,
    input  Parity_Err,
    input  Frame_Err,
    input  Busy_Sig
  );

  modport slave (
    input  RX_En_Sig,
    input  RX_Pin_In,
    output RX_Data,
    output RX_Done_Sig,
    output Parity_Err,
    output Frame_Err,
    output Busy_Sig
  );
endinterface

// File: rtl/uart_rx_param_ctl.sv
// Oversampling UART receiver with built-in baud tick, synchroniser, start-edge detect,
// 3-sample majority vote per bit, optional parity and 1/2 stop bits.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a falling edge on the line while enabled
// ST_START | start bit; voted 1 means false start, back to idle
// ST_DATA  | data bits, LSB first, into the shift register
// ST_PAR   | parity bit compared against XOR of the data bits
// ST_STOP  | stop bit(s); last one exits at its final vote sample
// ST_DONE  | one cycle; word and flags published, Done pulse high
module uart_rx_param_ctl #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                CLK,
  input  logic                RSTn,
  uart_rx_param_ctl_if.slave  rx_if
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W     = $clog2(OVERSAMPLE);
  localparam int B_W     = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LOAD  = DIV_W'(DIV - 1);
  localparam logic [S_W-1:0]   S_V0      = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0]   S_V1      = S_W'(OVERSAMPLE / 2);
  localparam logic [S_W-1:0]   S_V2      = S_W'(OVERSAMPLE / 2 + 1);
  localparam logic [S_W-1:0]   S_LAST    = S_W'(OVERSAMPLE - 1);
  localparam logic [B_W-1:0]   B_LAST    = B_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             ODD       = (PARITY == 1);
  localparam logic             HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 prev_q, prev_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [S_W-1:0]       s_cnt_q, s_cnt_d;
  logic [B_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 v0_q, v0_d;
  logic                 v1_q, v1_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;

  logic start_edge;
  logic tick;
  logic vote;
  logic vote_tick;
  logic bit_end;

  always_comb begin
    sync1_d    = rx_if.RX_Pin_In;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    start_edge = prev_q & ~sync2_q;

    tick      = (div_cnt_q == '0);
    div_cnt_d = tick ? DIV_LOAD : div_cnt_q - 1'b1;

    // Third vote sample is the live synchronised line on the S_V2 tick.
    vote      = (v0_q & v1_q) | (v0_q & sync2_q) | (v1_q & sync2_q);
    vote_tick = tick && (s_cnt_q == S_V2);
    bit_end   = tick && (s_cnt_q == S_LAST);

    state_d    = state_q;
    s_cnt_d    = s_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    done_d     = 1'b0;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;

    if (state_q != ST_IDLE && tick) begin
      s_cnt_d = (s_cnt_q == S_LAST) ? '0 : s_cnt_q + 1'b1;
      if (s_cnt_q == S_V0) v0_d = sync2_q;
      if (s_cnt_q == S_V1) v1_d = sync2_q;
    end

    if (!rx_if.RX_En_Sig) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_edge) begin
            state_d    = ST_START;
            div_cnt_d  = DIV_LOAD;
            s_cnt_d    = '0;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            shreg_d    = '0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
          end
        end
        ST_START: begin
          if (vote_tick && vote) begin
            state_d = ST_IDLE;
          end else if (bit_end) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          if (vote_tick) shreg_d[bit_cnt_q] = vote;
          if (bit_end) begin
            if (bit_cnt_q == B_LAST) begin
              state_d    = HAS_PAR ? ST_PAR : ST_STOP;
              stop_cnt_d = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        ST_PAR: begin
          if (vote_tick) perr_d = vote ^ (^shreg_q) ^ ODD;
          if (bit_end) begin
            state_d    = ST_STOP;
            stop_cnt_d = 1'b0;
          end
        end
        ST_STOP: begin
          if (vote_tick) begin
            if (!vote) ferr_d = 1'b1;
            // Final stop bit leaves half a bit early so a back-to-back start edge is caught.
            if (stop_cnt_q == STOP_LAST) begin
              state_d    = ST_DONE;
              data_d     = shreg_q;
              perr_out_d = perr_q;
              ferr_out_d = ferr_q | ~vote;
              done_d     = 1'b1;
            end
          end else if (bit_end) begin
            stop_cnt_d = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= ST_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      div_cnt_q  <= DIV_LOAD;
      s_cnt_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      v0_q       <= 1'b1;
      v1_q       <= 1'b1;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      div_cnt_q  <= div_cnt_d;
      s_cnt_q    <= s_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
    end
  end

  assign rx_if.RX_Data     = data_q;
  assign rx_if.RX_Done_Sig = done_q;
  assign rx_if.Parity_Err  = perr_out_q;
  assign rx_if.Frame_Err   = ferr_out_q;
  assign rx_if.Busy_Sig    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param_ctl.sv
// Scoreboard bench for uart_rx_param_ctl: four receivers (8N1, 8E1, 8N2, 9N1) each on its own line.
// Expected words are queued as frames are driven and popped when RX_Done_Sig fires.
module tb_uart_rx_param_ctl;

  localparam int CLK_FREQ = 50000000;
  localparam int BAUD     = 115200;
  localparam int OS       = 16;
  localparam int DIV      = CLK_FREQ / (BAUD * OS);
  localparam int BIT      = DIV * OS;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic pin [4] = '{default: 1'b1};
  logic en  [4] = '{default: 1'b1};

  uart_rx_param_ctl_if #(.DATA_BITS(8)) if0 ();
  uart_rx_param_ctl_if #(.DATA_BITS(8)) if1 ();
  uart_rx_param_ctl_if #(.DATA_BITS(8)) if2 ();
  uart_rx_param_ctl_if #(.DATA_BITS(9)) if3 ();

  assign if0.RX_Pin_In = pin[0];
  assign if0.RX_En_Sig = en[0];
  assign if1.RX_Pin_In = pin[1];
  assign if1.RX_En_Sig = en[1];
  assign if2.RX_Pin_In = pin[2];
  assign if2.RX_En_Sig = en[2];
  assign if3.RX_Pin_In = pin[3];
  assign if3.RX_En_Sig = en[3];

  uart_rx_param_ctl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                      .STOP_BITS(1), .OVERSAMPLE(OS))
    u_8n1 (.CLK(clk), .RSTn(rst_n), .rx_if(if0));
  uart_rx_param_ctl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
                      .STOP_BITS(1), .OVERSAMPLE(OS))
    u_8e1 (.CLK(clk), .RSTn(rst_n), .rx_if(if1));
  uart_rx_param_ctl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                      .STOP_BITS(2), .OVERSAMPLE(OS))
    u_8n2 (.CLK(clk), .RSTn(rst_n), .rx_if(if2));
  uart_rx_param_ctl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(9), .PARITY(0),
                      .STOP_BITS(1), .OVERSAMPLE(OS))
    u_9n1 (.CLK(clk), .RSTn(rst_n), .rx_if(if3));

  logic       done_w [4];
  logic [8:0] data_w [4];
  logic       perr_w [4];
  logic       ferr_w [4];
  logic       busy_w [4];

  assign done_w[0] = if0.RX_Done_Sig;
  assign done_w[1] = if1.RX_Done_Sig;
  assign done_w[2] = if2.RX_Done_Sig;
  assign done_w[3] = if3.RX_Done_Sig;
  assign data_w[0] = {1'b0, if0.RX_Data};
  assign data_w[1] = {1'b0, if1.RX_Data};
  assign data_w[2] = {1'b0, if2.RX_Data};
  assign data_w[3] = if3.RX_Data;
  assign perr_w[0] = if0.Parity_Err;
  assign perr_w[1] = if1.Parity_Err;
  assign perr_w[2] = if2.Parity_Err;
  assign perr_w[3] = if3.Parity_Err;
  assign ferr_w[0] = if0.Frame_Err;
  assign ferr_w[1] = if1.Frame_Err;
  assign ferr_w[2] = if2.Frame_Err;
  assign ferr_w[3] = if3.Frame_Err;
  assign busy_w[0] = if0.Busy_Sig;
  assign busy_w[1] = if1.Busy_Sig;
  assign busy_w[2] = if2.Busy_Sig;
  assign busy_w[3] = if3.Busy_Sig;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t sbq [4][$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt  [4] = '{default: 0};
  logic prev_done [4] = '{default: 1'b0};

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (done_w[i] === 1'b1) begin
        done_cnt[i]++;
        checks++;
        if (prev_done[i] === 1'b1) begin
          errors++;
          $display("FAIL done_width dut%0d: got Done high two cycles, required single-cycle pulse", i);
        end
        checks++;
        if (sbq[i].size() == 0) begin
          errors++;
          $display("FAIL unexpected_done dut%0d: got Done with data %0h, required no Done", i, data_w[i]);
        end else begin
          e = sbq[i].pop_front();
          if ({data_w[i], perr_w[i], ferr_w[i]} !== {e.data, e.perr, e.ferr}) begin
            errors++;
            $display("FAIL frame dut%0d: got data %0h perr %0b ferr %0b, required data %0h perr %0b ferr %0b",
                     i, data_w[i], perr_w[i], ferr_w[i], e.data, e.perr, e.ferr);
          end
        end
      end
      prev_done[i] = done_w[i];
    end
  end

  task automatic drive_bit(input int idx, input logic v, input int cycles);
    pin[idx] = v;
    repeat (cycles) @(negedge clk);
  endtask

  // pbit < 0 means no parity bit on the line; parity receivers here use even parity.
  task automatic send_frame(input int idx, input logic [8:0] d, input int nbits, input int pbit,
                            input logic [1:0] stops, input int nstop, input int spike_bit);
    exp_t e;
    logic x;
    x = 1'b0;
    e.data = '0;
    for (int i = 0; i < nbits; i++) begin
      e.data[i] = d[i];
      x = x ^ d[i];
    end
    e.perr = (pbit >= 0) ? (pbit[0] != x) : 1'b0;
    e.ferr = (nstop == 1) ? ~stops[0] : ~(stops[0] & stops[1]);
    sbq[idx].push_back(e);
    drive_bit(idx, 1'b0, BIT);
    for (int i = 0; i < nbits; i++) begin
      if (i == spike_bit && d[i]) begin
        drive_bit(idx, 1'b1, BIT / 2 - DIV / 2);
        drive_bit(idx, 1'b0, DIV);
        drive_bit(idx, 1'b1, BIT - (BIT / 2 - DIV / 2) - DIV);
      end else begin
        drive_bit(idx, d[i], BIT);
      end
    end
    if (pbit >= 0) drive_bit(idx, pbit[0], BIT);
    for (int i = 0; i < nstop; i++) drive_bit(idx, stops[i], BIT);
  endtask

  task automatic wait_drain(input int idx);
    for (int k = 0; k < 2 * BIT && sbq[idx].size() != 0; k++) @(negedge clk);
    checks++;
    if (sbq[idx].size() != 0) begin
      errors++;
      $display("FAIL drain_timeout dut%0d: got %0d frames outstanding, required 0", idx, sbq[idx].size());
      sbq[idx].delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({done_w[i], data_w[i], perr_w[i], ferr_w[i], busy_w[i]} !== 13'b0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got done %0b data %0h perr %0b ferr %0b busy %0b, required all 0",
                 i, done_w[i], data_w[i], perr_w[i], ferr_w[i], busy_w[i]);
      end
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (busy_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy %0b, required 0", busy_w[0]);
    end
  endtask

  task automatic test_basic();
    int c0;
    c0 = done_cnt[0];
    send_frame(0, 9'h0A5, 8, -1, 2'b11, 1, -1);
    wait_drain(0);
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt[0] - c0 !== 1) begin
      errors++;
      $display("FAIL basic_done_count: got %0d pulses, required 1", done_cnt[0] - c0);
    end
    checks++;
    if ({busy_w[0], data_w[0]} !== {1'b0, 9'h0A5}) begin
      errors++;
      $display("FAIL basic_after: got busy %0b data %0h, required busy 0 data a5", busy_w[0], data_w[0]);
    end
  endtask

  task automatic test_parity();
    send_frame(1, 9'h007, 8, 0, 2'b11, 1, -1);
    wait_drain(1);
    drive_bit(1, 1'b1, BIT);
    checks++;
    if (perr_w[1] !== 1'b1) begin
      errors++;
      $display("FAIL parity_bad_hold: got Parity_Err %0b, required 1", perr_w[1]);
    end
    send_frame(1, 9'h007, 8, 1, 2'b11, 1, -1);
    wait_drain(1);
    drive_bit(1, 1'b1, BIT);
    checks++;
    if (perr_w[1] !== 1'b0) begin
      errors++;
      $display("FAIL parity_good_hold: got Parity_Err %0b, required 0", perr_w[1]);
    end
  endtask

  task automatic test_framing();
    send_frame(0, 9'h055, 8, -1, 2'b00, 1, -1);
    wait_drain(0);
    drive_bit(0, 1'b1, BIT);
    send_frame(2, 9'h055, 8, -1, 2'b01, 2, -1);
    wait_drain(2);
    drive_bit(2, 1'b1, BIT);
    checks++;
    if (ferr_w[2] !== 1'b1) begin
      errors++;
      $display("FAIL frame_second_stop: got Frame_Err %0b, required 1", ferr_w[2]);
    end
    send_frame(2, 9'h0C3, 8, -1, 2'b11, 2, -1);
    wait_drain(2);
    drive_bit(2, 1'b1, BIT);
  endtask

  task automatic test_glitch();
    int c0;
    int k;
    c0 = done_cnt[0];
    drive_bit(0, 1'b0, 100);
    checks++;
    if (busy_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_rise: got busy %0b, required 1", busy_w[0]);
    end
    pin[0] = 1'b1;
    for (k = 100; k < BIT && busy_w[0] !== 1'b0; k++) @(negedge clk);
    checks++;
    if (busy_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy_fall: got busy %0b after %0d cycles, required 0", busy_w[0], k);
    end
    drive_bit(0, 1'b1, 2 * BIT);
    checks++;
    if (done_cnt[0] !== c0) begin
      errors++;
      $display("FAIL glitch_no_done: got %0d pulses, required 0", done_cnt[0] - c0);
    end
    send_frame(0, 9'h0FF, 8, -1, 2'b11, 1, 3);
    wait_drain(0);
    drive_bit(0, 1'b1, BIT);
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = done_cnt[0];
    send_frame(0, 9'h000, 8, -1, 2'b11, 1, -1);
    send_frame(0, 9'h0FF, 8, -1, 2'b11, 1, -1);
    wait_drain(0);
    drive_bit(0, 1'b1, BIT);
    checks++;
    if (done_cnt[0] - c0 !== 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d pulses, required 2", done_cnt[0] - c0);
    end
    send_frame(3, 9'h1A5, 9, -1, 2'b11, 1, -1);
    wait_drain(3);
    drive_bit(3, 1'b1, BIT);
  endtask

  task automatic test_enable_abort();
    int c0;
    send_frame(0, 9'h03C, 8, -1, 2'b11, 1, -1);
    wait_drain(0);
    drive_bit(0, 1'b1, BIT);
    c0 = done_cnt[0];
    drive_bit(0, 1'b0, BIT);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b1, BIT);
    drive_bit(0, 1'b1, BIT / 2);
    en[0] = 1'b0;
    for (int k = 0; k < 2 && busy_w[0] !== 1'b0; k++) @(negedge clk);
    checks++;
    if (busy_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got busy %0b, required 0 within 2 cycles", busy_w[0]);
    end
    drive_bit(0, 1'b1, 2 * BIT);
    checks++;
    if ({done_cnt[0] - c0, data_w[0]} !== {32'd0, 9'h03C}) begin
      errors++;
      $display("FAIL abort_hold: got %0d pulses data %0h, required 0 pulses data 3c",
               done_cnt[0] - c0, data_w[0]);
    end
    en[0] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    drive_bit(0, 1'b0, BIT);
    drive_bit(0, 1'b1, BIT + BIT / 2);
    checks++;
    if ({busy_w[0], data_w[0]} !== {1'b1, 9'h03C}) begin
      errors++;
      $display("FAIL midframe_pre: got busy %0b data %0h, required busy 1 data 3c", busy_w[0], data_w[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({done_w[0], data_w[0], perr_w[0], ferr_w[0], busy_w[0]} !== 13'b0) begin
      errors++;
      $display("FAIL midframe_reset: got done %0b data %0h perr %0b ferr %0b busy %0b, required all 0",
               done_w[0], data_w[0], perr_w[0], ferr_w[0], busy_w[0]);
    end
    @(negedge clk);
    pin[0] = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #2;
    @(negedge clk);
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_enable_abort();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param_ctl.md
Name: uart_rx_param_ctl

Overview:
Parametrised UART receive controller for the UART_RX path.
- Integrates its own oversampling baud tick generator, input synchroniser and start-edge detection; no external bps clock or edge detector is needed.
- Supports configurable data width, optional odd/even parity and 1 or 2 stop bits.
- Majority-votes each bit; reports parity and framing errors alongside each received word.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits; 1 or 2
OVERSAMPLE, 16, ticks per bit; legal range 8..32, even

Ports:
CLK  in  1  system clock; all logic on rising edge
RSTn  in  1  reset, asynchronous, active-low
RX_En_Sig  in  1  receiver enable; low aborts any frame and holds the block idle
RX_Pin_In  in  1  asynchronous serial line; idles high
RX_Data  out  DATA_BITS  last received word, LSB = first data bit on the line
RX_Done_Sig  out  1  one-CLK pulse: frame complete; RX_Data and error flags valid
Parity_Err  out  1  parity mismatch on last frame; always 0 when PARITY = 0
Frame_Err  out  1  at least one stop bit sampled low on last frame
Busy_Sig  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: RX_Data = 0, RX_Done_Sig = 0, Parity_Err = 0, Frame_Err = 0, Busy_Sig = 0, FSM = IDLE. Both synchroniser flops reset to 1.
- Synchroniser: 2 flops on RX_Pin_In, plus a third "previous" flop for edge detection. Start edge = previous 1 AND current 0.
- Tick generator: DIV = CLK_FREQ / (BAUD * OVERSAMPLE), integer division, minimum 1.
  - Counts 0..DIV-1 and emits a 1-CLK tick at terminal count.
  - Cleared on start-edge detection so bit phase aligns to the edge.
- Per bit, sample counter s runs 0..OVERSAMPLE-1 on ticks. The line is sampled at s = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1; bit value = majority of the three.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE: on start edge with RX_En_Sig = 1, go to START and clear counters. Edges are ignored while RX_En_Sig = 0.
  - START: after the vote, a voted 1 is a false start: return to IDLE, no Done, flags unchanged. Otherwise, at s = OVERSAMPLE-1 on a tick, go to DATA with bit_cnt = 0.
  - DATA: store the voted bit into shift register position bit_cnt (LSB first).
    - At the end of each bit, increment bit_cnt.
    - After bit DATA_BITS-1, go to PARITY if PARITY != 0, else go to STOP.
  - PARITY: perr = voted bit XOR (XOR of data bits) XOR (PARITY == 1). Go to STOP at end of bit.
  - STOP: vote each stop bit; any 0 sets ferr.
    - A non-final stop bit runs a full OVERSAMPLE ticks.
    - The final stop bit ends on the tick of its last vote sample (s = OVERSAMPLE/2+1). This half-bit early exit allows re-sync to a back-to-back start bit.
  - DONE: one CLK. RX_Data <= shift register, Parity_Err <= perr, Frame_Err <= ferr, RX_Done_Sig = 1. Then go to IDLE.
- Latency: RX_Done_Sig rises on the CLK edge following the final stop-bit vote tick.
- RX_Data and the error flags update only in DONE and hold until the next DONE.
- An errored frame still produces RX_Done_Sig and updates RX_Data.
- RX_Done_Sig is never high for two consecutive cycles.
- RX_En_Sig falling mid-frame: FSM goes to IDLE on the next CLK; no Done pulse; outputs hold; partial data is discarded.
- RSTn asserted mid-frame: all outputs clear immediately (asynchronous).
- Busy_Sig is combinational from the state register and deasserts in the same cycle the FSM reaches IDLE.

Test Plan:
Default parameters unless stated. DIV = 27, bit period = 432 CLK.
1. 8N1, send 0xA5 with valid stop -> exactly one RX_Done_Sig pulse of 1 CLK; RX_Data = 0xA5; Parity_Err = 0; Frame_Err = 0; Busy_Sig = 0 afterwards.
2. PARITY = 2, send 0x07 with parity bit 0 (correct bit is 1) -> RX_Done_Sig pulses, RX_Data = 0x07, Parity_Err = 1. Then send 0x07 with parity bit 1 -> Parity_Err = 0.
3. Send 0x55 with stop bit driven low -> RX_Done_Sig pulses, RX_Data = 0x55, Frame_Err = 1. STOP_BITS = 2 with only the second stop bit low -> Frame_Err = 1.
4. Low glitch of 100 CLK on an idle line; separately, a 1-tick low spike at the centre of data bit 3 of 0xFF -> glitch gives no Done and Busy_Sig returns to 0 within one bit period; spike frame gives RX_Data = 0xFF via majority vote.
5. Back-to-back 0x00 then 0xFF, next start bit immediately after the stop bit -> two Done pulses, RX_Data = 0x00 then 0xFF, no errors. DATA_BITS = 9 with 0x1A5 -> RX_Data = 0x1A5.
6. Deassert RX_En_Sig during data bit 3 after a prior 0x3C frame -> Busy_Sig = 0 within 2 CLK, no Done, RX_Data stays 0x3C. Assert RSTn = 0 mid-frame -> all outputs 0 immediately.
